// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with registered ALU-control decode, EX/MEM and MEM/WB operand
// forwarding, and load-use hazard detection.
module id_ex_stage #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned REGBITS = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               hold,
    input  logic               flush,
    input  logic               id_valid,
    input  logic [REGBITS-1:0] id_rs,
    input  logic [REGBITS-1:0] id_rt,
    input  logic [REGBITS-1:0] id_rd,
    input  logic [WIDTH-1:0]   id_rs_data,
    input  logic [WIDTH-1:0]   id_rt_data,
    input  logic [WIDTH-1:0]   id_imm,
    input  logic [1:0]         id_aluop,
    input  logic [5:0]         id_funct,
    input  logic               id_alusrc,
    input  logic               id_regdst,
    input  logic               id_regwrite,
    input  logic               id_memread,
    input  logic               id_memwrite,
    input  logic               id_memtoreg,
    input  logic               exmem_regwrite,
    input  logic [REGBITS-1:0] exmem_rd,
    input  logic [WIDTH-1:0]   exmem_result,
    input  logic               memwb_regwrite,
    input  logic [REGBITS-1:0] memwb_rd,
    input  logic [WIDTH-1:0]   memwb_result,
    output logic               load_use_stall,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    output logic [2:0]         alu_control,
    output logic [WIDTH-1:0]   ex_store_data,
    output logic [REGBITS-1:0] ex_write_reg,
    output logic               ex_valid,
    output logic               ex_regwrite,
    output logic               ex_memread,
    output logic               ex_memwrite,
    output logic               ex_memtoreg,
    output logic               illegal_funct
);

    logic [REGBITS-1:0] r_rs, r_rt, r_write_reg;
    logic [WIDTH-1:0]   r_rs_data, r_rt_data, r_imm;
    logic               r_valid, r_alusrc, r_regwrite, r_memread, r_memwrite, r_memtoreg;
    logic               r_illegal;
    logic [2:0]         r_alu_control;

    logic [2:0]         w_alu_control;
    logic               w_illegal;
    logic [WIDTH-1:0]   w_src_a, w_src_b;

    always_comb begin
        w_alu_control = 3'b010;
        w_illegal     = 1'b0;
        case (id_aluop)
            2'b01:   w_alu_control = 3'b110;
            2'b11:   w_alu_control = 3'b111;
            2'b10: begin
                case (id_funct)
                    6'b100000: w_alu_control = 3'b010;
                    6'b100010: w_alu_control = 3'b110;
                    6'b100100: w_alu_control = 3'b000;
                    6'b100101: w_alu_control = 3'b001;
                    6'b101010: w_alu_control = 3'b111;
                    default:   w_illegal     = id_valid;
                endcase
            end
            default: w_alu_control = 3'b010;
        endcase
    end

    always_comb begin
        load_use_stall = r_valid && r_memread && (r_rt != '0) && id_valid &&
                         ((r_rt == id_rs) || (r_rt == id_rt));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rs          <= '0;
            r_rt          <= '0;
            r_write_reg   <= '0;
            r_rs_data     <= '0;
            r_rt_data     <= '0;
            r_imm         <= '0;
            r_alusrc      <= 1'b0;
            r_valid       <= 1'b0;
            r_regwrite    <= 1'b0;
            r_memread     <= 1'b0;
            r_memwrite    <= 1'b0;
            r_memtoreg    <= 1'b0;
            r_illegal     <= 1'b0;
            r_alu_control <= 3'b010;
        end else if (!hold) begin
            // Data fields load even on a bubble; with control zeroed they have no effect.
            r_rs        <= id_rs;
            r_rt        <= id_rt;
            r_write_reg <= id_regdst ? id_rd : id_rt;
            r_rs_data   <= id_rs_data;
            r_rt_data   <= id_rt_data;
            r_imm       <= id_imm;
            r_alusrc    <= id_alusrc;
            if (flush || load_use_stall) begin
                r_valid       <= 1'b0;
                r_regwrite    <= 1'b0;
                r_memread     <= 1'b0;
                r_memwrite    <= 1'b0;
                r_memtoreg    <= 1'b0;
                r_illegal     <= 1'b0;
                r_alu_control <= 3'b010;
            end else begin
                r_valid       <= id_valid;
                r_regwrite    <= id_regwrite;
                r_memread     <= id_memread;
                r_memwrite    <= id_memwrite;
                r_memtoreg    <= id_memtoreg;
                r_illegal     <= w_illegal;
                r_alu_control <= w_alu_control;
            end
        end
    end

    // EX/MEM is the younger result, so it takes priority over MEM/WB.
    always_comb begin
        w_src_a = r_rs_data;
        if (exmem_regwrite && (exmem_rd != '0) && (exmem_rd == r_rs)) begin
            w_src_a = exmem_result;
        end else if (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == r_rs)) begin
            w_src_a = memwb_result;
        end
        w_src_b = r_rt_data;
        if (exmem_regwrite && (exmem_rd != '0) && (exmem_rd == r_rt)) begin
            w_src_b = exmem_result;
        end else if (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == r_rt)) begin
            w_src_b = memwb_result;
        end
    end

    always_comb begin
        alu_a         = w_src_a;
        alu_b         = r_alusrc ? r_imm : w_src_b;
        ex_store_data = w_src_b;
        alu_control   = r_alu_control;
        ex_write_reg  = r_write_reg;
        ex_valid      = r_valid;
        ex_regwrite   = r_regwrite;
        ex_memread    = r_memread;
        ex_memwrite   = r_memwrite;
        ex_memtoreg   = r_memtoreg;
        illegal_funct = r_illegal;
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: table of decode/forwarding vectors plus
// hand-written reset, load-use, hold/flush and reset-under-hold sequences.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset, hold, flush, id_valid;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic [1:0]  id_aluop;
    logic [5:0]  id_funct;
    logic        id_alusrc, id_regdst, id_regwrite, id_memread, id_memwrite, id_memtoreg;
    logic        exmem_regwrite, memwb_regwrite;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_result, memwb_result;
    logic        load_use_stall;
    logic [31:0] alu_a, alu_b, ex_store_data;
    logic [2:0]  alu_control;
    logic [4:0]  ex_write_reg;
    logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, illegal_funct;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.WIDTH(32), .REGBITS(5)) dut (
        .clk(clk), .reset(reset), .hold(hold), .flush(flush), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_aluop(id_aluop), .id_funct(id_funct), .id_alusrc(id_alusrc),
        .id_regdst(id_regdst), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg),
        .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .load_use_stall(load_use_stall), .alu_a(alu_a), .alu_b(alu_b),
        .alu_control(alu_control), .ex_store_data(ex_store_data),
        .ex_write_reg(ex_write_reg), .ex_valid(ex_valid), .ex_regwrite(ex_regwrite),
        .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg),
        .illegal_funct(illegal_funct)
    );

    typedef struct {
        logic [1:0]  aluop;
        logic [5:0]  funct;
        logic        alusrc;
        logic        regdst;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [31:0] rs_d;
        logic [31:0] rt_d;
        logic [31:0] imm;
        logic        xw;
        logic [4:0]  xrd;
        logic [31:0] xres;
        logic        mw;
        logic [4:0]  mrd;
        logic [31:0] mres;
        logic [31:0] ea;
        logic [31:0] eb;
        logic [31:0] es;
        logic [2:0]  ec;
        logic        ei;
        logic [4:0]  ewr;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic defaults();
        hold = 0; flush = 0; id_valid = 0;
        id_rs = 0; id_rt = 0; id_rd = 0;
        id_rs_data = 0; id_rt_data = 0; id_imm = 0;
        id_aluop = 0; id_funct = 0;
        id_alusrc = 0; id_regdst = 0; id_regwrite = 0;
        id_memread = 0; id_memwrite = 0; id_memtoreg = 0;
        exmem_regwrite = 0; exmem_rd = 0; exmem_result = 0;
        memwb_regwrite = 0; memwb_rd = 0; memwb_result = 0;
    endtask

    initial begin
        vecs[0]  = '{2'b10, 6'b101010, 1'b0, 1'b1, 5'd1, 5'd2, 32'd5, 32'd9, 32'd0,
                     1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd5, 32'd9, 32'd9, 3'b111, 1'b0, 5'd3};
        vecs[1]  = '{2'b10, 6'b100100, 1'b0, 1'b1, 5'd1, 5'd2, 32'd5, 32'd9, 32'd0,
                     1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd5, 32'd9, 32'd9, 3'b000, 1'b0, 5'd3};
        vecs[2]  = '{2'b10, 6'b000000, 1'b0, 1'b0, 5'd1, 5'd2, 32'd5, 32'd9, 32'd0,
                     1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd5, 32'd9, 32'd9, 3'b010, 1'b1, 5'd2};
        vecs[3]  = '{2'b10, 6'b100101, 1'b0, 1'b1, 5'd1, 5'd2, 32'h0F0, 32'h00F, 32'd0,
                     1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'h0F0, 32'h00F, 32'h00F, 3'b001,
                     1'b0, 5'd3};
        vecs[4]  = '{2'b01, 6'b000000, 1'b0, 1'b0, 5'd1, 5'd2, 32'h40, 32'h30, 32'd0,
                     1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'h40, 32'h30, 32'h30, 3'b110,
                     1'b0, 5'd2};
        vecs[5]  = '{2'b11, 6'b111111, 1'b1, 1'b0, 5'd1, 5'd2, 32'h40, 32'h30, 32'h7,
                     1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'h40, 32'h7, 32'h30, 3'b111,
                     1'b0, 5'd2};
        vecs[6]  = '{2'b00, 6'b000000, 1'b0, 1'b1, 5'd3, 5'd2, 32'h11, 32'h22, 32'd0,
                     1'b1, 5'd3, 32'hAAAA0000, 1'b1, 5'd3, 32'h5555, 32'hAAAA0000, 32'h22,
                     32'h22, 3'b010, 1'b0, 5'd3};
        vecs[7]  = '{2'b00, 6'b000000, 1'b0, 1'b1, 5'd3, 5'd2, 32'h11, 32'h22, 32'd0,
                     1'b0, 5'd3, 32'hAAAA0000, 1'b1, 5'd3, 32'h5555, 32'h5555, 32'h22,
                     32'h22, 3'b010, 1'b0, 5'd3};
        vecs[8]  = '{2'b00, 6'b000000, 1'b0, 1'b1, 5'd0, 5'd0, 32'h77, 32'h88, 32'd0,
                     1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 32'hBEEF, 32'h77, 32'h88, 32'h88,
                     3'b010, 1'b0, 5'd3};
        vecs[9]  = '{2'b00, 6'b000000, 1'b1, 1'b0, 5'd1, 5'd4, 32'h33, 32'h44, 32'hFFFFFFFC,
                     1'b1, 5'd4, 32'h10, 1'b0, 5'd0, 32'd0, 32'h33, 32'hFFFFFFFC, 32'h10,
                     3'b010, 1'b0, 5'd4};
        vecs[10] = '{2'b10, 6'b100010, 1'b0, 1'b1, 5'd1, 5'd5, 32'h50, 32'h60, 32'd0,
                     1'b1, 5'd6, 32'h1, 1'b1, 5'd5, 32'h99, 32'h50, 32'h99, 32'h99, 3'b110,
                     1'b0, 5'd3};
        vecs[11] = '{2'b10, 6'b100000, 1'b0, 1'b1, 5'd7, 5'd7, 32'h1, 32'h2, 32'd0,
                     1'b1, 5'd7, 32'hCAFE, 1'b1, 5'd7, 32'h1, 32'hCAFE, 32'hCAFE, 32'hCAFE,
                     3'b010, 1'b0, 5'd3};

        // Reset dominates hold.
        defaults();
        reset = 1; hold = 1;
        tick();
        tick();
        chk("rst_valid", 32'(ex_valid), 32'd0);
        chk("rst_ctrl", 32'(alu_control), 32'd2);
        chk("rst_regwrite", 32'(ex_regwrite), 32'd0);
        chk("rst_illegal", 32'(illegal_funct), 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_b", alu_b, 32'd0);
        reset = 0; hold = 0;

        for (int i = 0; i < 12; i++) begin
            vec_t v;
            v = vecs[i];
            defaults();
            id_valid = 1; id_regwrite = 1; id_rd = 5'd3;
            id_aluop = v.aluop; id_funct = v.funct; id_alusrc = v.alusrc; id_regdst = v.regdst;
            id_rs = v.rs; id_rt = v.rt; id_rs_data = v.rs_d; id_rt_data = v.rt_d;
            id_imm = v.imm;
            exmem_regwrite = v.xw; exmem_rd = v.xrd; exmem_result = v.xres;
            memwb_regwrite = v.mw; memwb_rd = v.mrd; memwb_result = v.mres;
            tick();
            chk($sformatf("v%0d_alu_a", i), alu_a, v.ea);
            chk($sformatf("v%0d_alu_b", i), alu_b, v.eb);
            chk($sformatf("v%0d_store", i), ex_store_data, v.es);
            chk($sformatf("v%0d_ctrl", i), 32'(alu_control), 32'(v.ec));
            chk($sformatf("v%0d_illegal", i), 32'(illegal_funct), 32'(v.ei));
            chk($sformatf("v%0d_wreg", i), 32'(ex_write_reg), 32'(v.ewr));
            chk($sformatf("v%0d_valid", i), 32'(ex_valid), 32'd1);
            chk($sformatf("v%0d_stall", i), 32'(load_use_stall), 32'd0);
        end

        // Load-use: lw r8, then an add reading r8.
        defaults();
        id_valid = 1; id_rs = 1; id_rt = 8; id_imm = 4; id_alusrc = 1;
        id_regwrite = 1; id_memread = 1; id_memtoreg = 1;
        tick();
        chk("lw_memread", 32'(ex_memread), 32'd1);
        chk("lw_wreg", 32'(ex_write_reg), 32'd8);
        id_rs = 8; id_rt = 9; id_rd = 10; id_regdst = 1; id_alusrc = 0; id_imm = 0;
        id_memread = 0; id_memtoreg = 0; id_aluop = 2'b10; id_funct = 6'b100000;
        id_rs_data = 0; id_rt_data = 7;
        #1;
        chk("lu_stall", 32'(load_use_stall), 32'd1);
        tick();
        chk("lu_bubble_valid", 32'(ex_valid), 32'd0);
        chk("lu_bubble_regwrite", 32'(ex_regwrite), 32'd0);
        chk("lu_bubble_memread", 32'(ex_memread), 32'd0);
        chk("lu_bubble_ctrl", 32'(alu_control), 32'd2);
        chk("lu_stall_clear", 32'(load_use_stall), 32'd0);
        tick();
        memwb_regwrite = 1; memwb_rd = 8; memwb_result = 32'h1234;
        #1;
        chk("lu_dep_valid", 32'(ex_valid), 32'd1);
        chk("lu_dep_alu_a", alu_a, 32'h1234);
        chk("lu_dep_alu_b", alu_b, 32'd7);
        chk("lu_dep_wreg", 32'(ex_write_reg), 32'd10);
        chk("lu_dep_stall", 32'(load_use_stall), 32'd0);

        // Hold beats flush; then a plain flush bubbles.
        defaults();
        id_valid = 1; id_rs = 2; id_rt = 3; id_rs_data = 32'h100; id_rt_data = 32'h200;
        id_alusrc = 1; id_imm = 8; id_memwrite = 1;
        tick();
        chk("sw_memwrite", 32'(ex_memwrite), 32'd1);
        chk("sw_alu_b", alu_b, 32'd8);
        id_rs_data = 32'h999; id_imm = 1; id_memwrite = 0;
        hold = 1; flush = 1;
        tick();
        chk("hold_valid", 32'(ex_valid), 32'd1);
        chk("hold_memwrite", 32'(ex_memwrite), 32'd1);
        chk("hold_alu_a", alu_a, 32'h100);
        chk("hold_alu_b", alu_b, 32'd8);
        hold = 0;
        id_memwrite = 1;
        tick();
        chk("flush_valid", 32'(ex_valid), 32'd0);
        chk("flush_memwrite", 32'(ex_memwrite), 32'd0);

        // Flush clears a registered illegal_funct.
        defaults();
        id_valid = 1; id_aluop = 2'b10; id_funct = 6'b111111;
        tick();
        chk("ill_set", 32'(illegal_funct), 32'd1);
        flush = 1;
        tick();
        chk("ill_flushed", 32'(illegal_funct), 32'd0);
        chk("ill_flushed_ctrl", 32'(alu_control), 32'd2);

        // Reset under hold clears the stage.
        defaults();
        id_valid = 1; id_regwrite = 1; id_aluop = 2'b01;
        tick();
        chk("pre_rst_regwrite", 32'(ex_regwrite), 32'd1);
        hold = 1; reset = 1;
        tick();
        chk("rst_hold_valid", 32'(ex_valid), 32'd0);
        chk("rst_hold_regwrite", 32'(ex_regwrite), 32'd0);
        chk("rst_hold_ctrl", 32'(alu_control), 32'd2);
        reset = 0; hold = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
ID/EX pipeline stage that feeds the 32-bit ALU. It registers decoded operands and control signals, and decodes ALUOp/funct into the 3-bit ALU control code. It resolves RAW hazards by forwarding from EX/MEM and MEM/WB, detects load-use hazards and inserts bubbles. It sits between the ID register file read and the ALU, and its outputs drive the ALU A, B and ALUControl inputs directly.

Parameters:
WIDTH, 32, datapath width (ALU is fixed at 32; other values unsupported)
REGBITS, 5, register specifier width

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
hold  in  1  downstream stall; freeze stage contents
flush  in  1  squash instruction entering this cycle (branch/jump redirect)
id_valid  in  1  ID holds a real instruction
id_rs, id_rt, id_rd  in  REGBITS each  register specifiers
id_rs_data, id_rt_data  in  WIDTH each  register file read data
id_imm  in  WIDTH  sign-extended immediate
id_aluop  in  2  00 add, 01 sub, 10 R-type (funct), 11 slti
id_funct  in  6  instruction funct field
id_alusrc, id_regdst, id_regwrite, id_memread, id_memwrite, id_memtoreg  in  1 each  main control
exmem_regwrite  in  1; exmem_rd  in  REGBITS; exmem_result  in  WIDTH  EX/MEM forwarding source
memwb_regwrite  in  1; memwb_rd  in  REGBITS; memwb_result  in  WIDTH  MEM/WB forwarding source
load_use_stall  out  1  to PC/IF-ID: hold fetch and decode
alu_a, alu_b  out  WIDTH each  ALU operands
alu_control  out  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
ex_store_data  out  WIDTH  forwarded rt value for sw
ex_write_reg  out  REGBITS  rt if !regdst, else rd
ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg  out  1 each
illegal_funct  out  1  registered; R-type funct not in supported set

Behaviour:
- Single clock, synchronous active-high reset. Register update priority: reset > hold > (flush | load_use_stall) > load.
- Reset: all registers zero, so ex_valid=0, all control outputs 0, alu_control=010, illegal_funct=0. With zero state, alu_a, alu_b and ex_store_data read 0 when no forwarding source matches.
- Load (no hold, no flush, no stall): every id_* field captured; latency 1 cycle from ID to outputs.
- Bubble (flush or load_use_stall, no hold): ex_valid, regwrite, memread, memwrite, memtoreg and illegal_funct = 0; alu_control = 010. Data fields are don't-care but must not produce side effects.
- hold: every register keeps its value. hold overrides flush; the flush is lost, and the upstream control must re-assert it.
- ALU control decode happens at load time and is registered:
  - aluop 00 -> 010; 01 -> 110; 11 -> 111.
  - aluop 10: funct 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111.
  - Any other funct -> 010 with illegal_funct=1 (only when id_valid).
- Forwarding is combinational on registered specifiers:
  - src_a = exmem_result if exmem_regwrite && exmem_rd!=0 && exmem_rd==ex_rs.
  - Otherwise memwb_result if memwb_regwrite && memwb_rd!=0 && memwb_rd==ex_rs.
  - Otherwise the registered rs_data.
  - EX/MEM always wins over MEM/WB. src_b follows the same rules on ex_rt.
- alu_a = src_a. alu_b = registered imm if alusrc, else src_b. ex_store_data = src_b always.
- load_use_stall (combinational) = ex_valid && ex_memread && ex_rt!=0 && id_valid && (ex_rt==id_rs || ex_rt==id_rt). It is asserted for exactly one cycle per load-use pair, then the bubble clears it.
- Register 0 is never forwarded and never causes a stall.
- Reset asserted mid-operation clears the stage on the next edge regardless of hold.

Test Plan:
- Reset: assert reset 2 cycles with hold=1 -> ex_valid=0, alu_control=010, regwrite=0, illegal_funct=0.
- R-type decode: aluop=10, funct=101010, rs_data=5, rt_data=9, no forwarding -> next cycle alu_a=5, alu_b=9, alu_control=111. Repeat with funct=100100 -> 000, and funct=000000 -> 010 with illegal_funct=1.
- Forward priority: ex_rs=3, exmem_rd=3 and memwb_rd=3 both regwrite, exmem_result=0xAAAA0000, memwb_result=0x5555 -> alu_a=0xAAAA0000. Clear exmem_regwrite -> alu_a=0x5555. Set rd=0 on both -> alu_a=rs_data.
- Immediate path: alusrc=1, imm=0xFFFFFFFC, rt forwarded 0x10 -> alu_b=0xFFFFFFFC, ex_store_data=0x10.
- Load-use: lw loaded with rt=8, memread=1; next ID has rs=8 -> load_use_stall=1 for one cycle, next ex_valid=0. The following cycle the dependent instruction loads, with memwb forwarding its value.
- Hold vs flush: hold=1 with flush=1 -> outputs unchanged. Then hold=0, flush=1 -> ex_valid=0, ex_memwrite=0.
